fifo_wr_arbiter: RTL

- Shares the write port of one FIFO (FIFO_WIDTH data, wr_en/wr_ack/full/almostfull/overflow handshake) between NUM_REQ requesters.
- Round-robin arbitration with burst locking: a granted requester owns the FIFO for up to MAX_BURST consecutive words.
- The arbiter throttles on full/almostfull so it never overflows the FIFO, and it checks every write against wr_ack/overflow.
- Sits between the producer blocks and the FIFO's DUT-side write inputs; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 73 +++++++
 rtl/fifo_wr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester-side handshake, the FIFO write-port handshake and the
//   arbiter status outputs into one interface.
//
//   Signals:
//     req_valid       [NUM_REQ]             per-requester word valid
//     req_data        [NUM_REQ*FIFO_WIDTH]  packed request data, requester i at
//                                           [i*FIFO_WIDTH +: FIFO_WIDTH]
//     req_ready       [NUM_REQ]             per-requester accept (combinational)
//     fifo_wr_en                            FIFO write enable (registered)
//     fifo_data_in    [FIFO_WIDTH]          FIFO write data (registered)
//     fifo_full                             FIFO full
//     fifo_almostfull                       FIFO has exactly one free slot
//     fifo_wr_ack                           write accepted, one cycle after wr_en
//     fifo_overflow                         write rejected, one cycle after wr_en
//     grant_id        [GRANT_W]             current owner, valid while busy
//     busy                                  arbiter is in a burst
//     ack_err                               one-cycle write-check error pulse
//
//   Modports:
//     master : the arbiter (drives ready, FIFO write port and status)
//     slave  : the environment (requesters + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16
);
   localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [FIFO_WIDTH-1:0]         fifo_data_in;
   logic                          fifo_full;
   logic                          fifo_almostfull;
   logic                          fifo_wr_ack;
   logic                          fifo_overflow;
   logic [GRANT_W-1:0]            grant_id;
   logic                          busy;
   logic                          ack_err;

   modport master (
      input  req_valid,
      input  req_data,
      output req_ready,
      output fifo_wr_en,
      output fifo_data_in,
      input  fifo_full,
      input  fifo_almostfull,
      input  fifo_wr_ack,
      input  fifo_overflow,
      output grant_id,
      output busy,
      output ack_err
   );

   modport slave (
      output req_valid,
      output req_data,
      input  req_ready,
      input  fifo_wr_en,
      input  fifo_data_in,
      output fifo_full,
      output fifo_almostfull,
      output fifo_wr_ack,
      output fifo_overflow,
      input  grant_id,
      input  busy,
      input  ack_err
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port of a single FIFO between NUM_REQ producers.
//   Round-robin arbitration with burst locking: the granted requester owns the
//   FIFO for up to MAX_BURST consecutive words, then must re-arbitrate.
//   Writes are throttled on full/almostfull so the FIFO never overflows, and
//   every issued write is checked against wr_ack/overflow.
//
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     bus          fifo_wr_arbiter_if.master (requester + FIFO write handshake,
//                  grant_id / busy / ack_err status)
//
//   Optional build macro FIFO_WR_ARB_STATS_EN adds:
//     ack_err_cnt [7:0]            saturating count of ack_err pulses
//     burst_cnt   [NUM_REQ*8-1:0]  8-bit wrapping grant counter per requester
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   fifo_wr_arbiter_if.master        bus
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [7:0]               ack_err_cnt,
   output logic [NUM_REQ*8-1:0]     burst_cnt
`endif
);

   localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [GRANT_W-1:0]    grant_q, grant_d;
   logic [GRANT_W-1:0]    last_q, last_d;
   logic [GRANT_W-1:0]    pick;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  wr_en_q, wr_en_d;
   logic [FIFO_WIDTH-1:0] data_q, data_d;
   logic                  expect_q;
   logic                  ack_err_q;
   logic                  ack_err_now;
   logic                  can_write;
   logic                  own_valid;
   logic [FIFO_WIDTH-1:0] own_data;
   logic                  xfer;
   logic                  last_beat;
   logic [NUM_REQ-1:0]    ready;

   // Round-robin pick: first valid requester after 'last', wrapping.
   // Scanning from the farthest candidate to the nearest lets the nearest
   // valid requester overwrite the result.
   function automatic logic [GRANT_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0] valid,
      input logic [GRANT_W-1:0] last
   );
      logic [GRANT_W-1:0] sel;
      int                 idx;
      sel = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (valid[idx]) begin
            sel = GRANT_W'(idx);
         end
      end
      return sel;
   endfunction

   // With a write already in flight, almostfull means that write takes the
   // last free slot, so a new word cannot be admitted this cycle.
   assign can_write = !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);

   assign pick = rr_pick(bus.req_valid, last_q);

   // Select the owner's valid/data without a variable-width part select.
   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            own_valid = bus.req_valid[i];
            own_data  = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   assign xfer      = (state_q == BURST) && own_valid && can_write;
   assign last_beat = (beat_q == BEAT_W'(MAX_BURST - 1));

   // Only the owner sees ready, and only while the FIFO can take a word.
   always_comb begin
      ready = '0;
      if (state_q == BURST) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = (grant_q == GRANT_W'(i)) && can_write;
         end
      end
   end

   // Next-state / datapath decode.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      wr_en_d = 1'b0;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               state_d = BURST;
               grant_d = pick;
               beat_d  = '0;
            end
         end
         BURST: begin
            if (xfer) begin
               wr_en_d = 1'b1;
               data_d  = own_data;
               beat_d  = beat_q + 1'b1;
            end
            // A stall (can_write low) never ends the burst; a released owner
            // is only noticed once the FIFO could have taken a word again.
            if ((!own_valid && can_write) || (xfer && last_beat)) begin
               state_d = IDLE;
               last_d  = grant_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stage p0 -> p1: arbitration state and registered FIFO write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GRANT_W'(NUM_REQ - 1);
         beat_q  <= '0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         wr_en_q <= wr_en_d;
         data_q  <= data_d;
      end
   end

   // Any disagreement between what was issued last cycle and what the FIFO
   // reports, plus any overflow at all, is an error.
   assign ack_err_now = (expect_q ^ bus.fifo_wr_ack) || bus.fifo_overflow;

   // Stage p1 -> p2: write-check pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expect_q  <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         expect_q  <= wr_en_q;
         ack_err_q <= ack_err_now;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_data_in = data_q;
   assign bus.grant_id     = grant_q;
   assign bus.busy         = (state_q == BURST);
   assign bus.ack_err      = ack_err_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic grant_evt;

   assign grant_evt = (state_q == IDLE) && (|bus.req_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_err_cnt <= '0;
      end else if (ack_err_q && (ack_err_cnt != 8'hFF)) begin
         ack_err_cnt <= ack_err_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (grant_evt) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GRANT_W'(i)) begin
               burst_cnt[i*8 +: 8] <= burst_cnt[i*8 +: 8] + 8'd1;
            end
         end
      end
   end
`endif

endmodule
